// File: rtl/pwm_duty_ramp.sv
// pwm_duty_ramp: debounced switch target, slewed or jumped duty committed only at PWM period boundaries
// Ports:
//   clk, rst_n (async, active-low)
//   sw         raw switch word (async to clk), synchronised and debounced into target_out
//   ramp_en    1 = step duty toward target once per tick, 0 = jump to target
//   period_end one-cycle pulse at PWM counter wrap; the only moment duty_out may change
//   duty_out   committed duty, duty_valid pulses alongside each new duty_out value
//   target_out debounced target, busy high while duty_out is still chasing it
module pwm_duty_ramp #(
    parameter int DUTY_W          = 8,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int STEP_DIV        = 100000,
    parameter int STEP            = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DUTY_W-1:0] sw,
    input  logic              ramp_en,
    input  logic              period_end,
    output logic [DUTY_W-1:0] duty_out,
    output logic              duty_valid,
    output logic [DUTY_W-1:0] target_out,
    output logic              busy
);
    localparam int SC_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int TC_W = $clog2(STEP_DIV);
    localparam int DW1  = DUTY_W + 1;
    localparam logic [SC_W-1:0]   STAB_MAX  = SC_W'(DEBOUNCE_CYCLES);
    localparam logic [SC_W-1:0]   STAB_LOAD = SC_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [TC_W-1:0]   TICK_LAST = TC_W'(STEP_DIV - 1);
    localparam logic [DW1-1:0]    STEP_X    = DW1'(STEP);
    localparam logic [DUTY_W-1:0] STEP_D    = DUTY_W'(STEP);

    typedef enum logic [1:0] {IDLE, WAIT_TICK, WAIT_EDGE} state_t;

    state_t            state, state_nx;
    logic [DUTY_W-1:0] sw_m, sw_s, cand, target, next_duty;
    logic [SC_W-1:0]   stab_cnt;
    logic [TC_W-1:0]   tick_cnt;
    logic [DW1-1:0]    up_gap, dn_gap;
    logic              tick, differ, commit;

    assign target_out = target;
    assign busy       = state != IDLE;
    assign tick       = tick_cnt == TICK_LAST;
    assign differ     = target != duty_out;
    // gaps are one bit wider so the clamp test never sees a wrapped difference
    assign up_gap     = {1'b0, target} - {1'b0, duty_out};
    assign dn_gap     = {1'b0, duty_out} - {1'b0, target};
    assign next_duty  = !ramp_en ? target :
                        (target > duty_out) ? ((up_gap <= STEP_X) ? target : duty_out + STEP_D) :
                                              ((dn_gap <= STEP_X) ? target : duty_out - STEP_D);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sw_m     <= '0;
            sw_s     <= '0;
            cand     <= '0;
            stab_cnt <= '0;
            target   <= '0;
            tick_cnt <= '0;
        end else begin
            sw_m     <= sw;
            sw_s     <= sw_m;
            cand     <= sw_s;
            // saturating, so the load compare below fires once per stable run
            stab_cnt <= (sw_s != cand) ? '0 : (stab_cnt == STAB_MAX) ? stab_cnt : stab_cnt + 1'b1;
            if (stab_cnt == STAB_LOAD) target <= cand;
            tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
        end
    end

    always_comb begin
        state_nx = state;
        commit   = 1'b0;
        case (state)
            IDLE:      if (differ) state_nx = ramp_en ? WAIT_TICK : WAIT_EDGE;
            WAIT_TICK: state_nx = !differ ? IDLE : (!ramp_en || tick) ? WAIT_EDGE : WAIT_TICK;
            WAIT_EDGE: begin
                if (!differ) state_nx = IDLE;
                else if (period_end) begin
                    commit   = 1'b1;
                    state_nx = (next_duty == target) ? IDLE : ramp_en ? WAIT_TICK : WAIT_EDGE;
                end
            end
            default:   state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            duty_out   <= '0;
            duty_valid <= 1'b0;
        end else begin
            state      <= state_nx;
            duty_valid <= commit;
            if (commit) duty_out <= next_duty;
        end
    end
endmodule

// File: tb/tb_pwm_duty_ramp.sv
// tb_pwm_duty_ramp: table, directed and random checks of pwm_duty_ramp against a behavioural model
module tb_pwm_duty_ramp;
    localparam int SDIV = 8;

    typedef struct {
        bit re;
        int sw;
        int exp_duty;
        int pulses;
    } rec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [7:0] sw = '0, sw4 = '0;
    logic       ramp_en = 1'b0, ramp4 = 1'b0, period_end = 1'b0, pe4 = 1'b0;
    logic [7:0] duty_out, target_out, duty4, target4;
    logic       duty_valid, busy, valid4, busy4;

    int vectors = 0;
    int miscompares = 0;

    int m_duty, m_tgt, m_edges;
    bit m_busy, m_armed, m_valid;
    int hist[7];

    always #5 clk = ~clk;

    pwm_duty_ramp #(.DUTY_W(8), .DEBOUNCE_CYCLES(4), .STEP_DIV(SDIV), .STEP(1)) u1 (
        .clk(clk), .rst_n(rst_n), .sw(sw), .ramp_en(ramp_en), .period_end(period_end),
        .duty_out(duty_out), .duty_valid(duty_valid), .target_out(target_out), .busy(busy)
    );

    pwm_duty_ramp #(.DUTY_W(8), .DEBOUNCE_CYCLES(4), .STEP_DIV(SDIV), .STEP(4)) u4 (
        .clk(clk), .rst_n(rst_n), .sw(sw4), .ramp_en(ramp4), .period_end(pe4),
        .duty_out(duty4), .duty_valid(valid4), .target_out(target4), .busy(busy4)
    );

    function automatic void check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void model_reset();
        m_duty = 0; m_tgt = 0; m_edges = 0;
        m_busy = 0; m_armed = 0; m_valid = 0;
        for (int i = 0; i < 7; i++) hist[i] = 0;
    endfunction

    // target rule: a switch value seen at four consecutive synchroniser outputs is accepted;
    // duty rule: commit only at period_end, after a tick when ramping, clamped integer steps
    function automatic void model_step();
        bit tk;
        int nxt;
        tk = (m_edges % SDIV) == SDIV - 1;
        m_edges++;
        m_valid = 0;
        if (!m_busy) begin
            if (m_tgt != m_duty) begin
                m_busy = 1;
                m_armed = !ramp_en;
            end
        end else if (m_tgt == m_duty) m_busy = 0;
        else if (!m_armed) begin
            if (!ramp_en || tk) m_armed = 1;
        end else if (period_end) begin
            if (!ramp_en) nxt = m_tgt;
            else if (m_tgt > m_duty) nxt = (m_duty + 1 < m_tgt) ? m_duty + 1 : m_tgt;
            else nxt = (m_duty - 1 > m_tgt) ? m_duty - 1 : m_tgt;
            m_duty = nxt;
            m_valid = 1;
            if (nxt == m_tgt) m_busy = 0;
            else m_armed = !ramp_en;
        end
        for (int i = 6; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = int'(sw);
        if (hist[3] == hist[4] && hist[4] == hist[5] && hist[5] == hist[6]) m_tgt = hist[3];
    endfunction

    function automatic void check_model();
        check("model", int'({duty_out, target_out, duty_valid, busy}),
              (m_duty << 10) | (m_tgt << 2) | (int'(m_valid) << 1) | int'(m_busy));
    endfunction

    task automatic tick1();
        @(posedge clk);
        model_step();
        #1;
        check_model();
    endtask

    task automatic run_rec(input bit re, input int s, input int exp_d, input int exp_p, input string tag);
        int p;
        p = 0;
        ramp_en = re;
        sw = 8'(s);
        for (int n = 0; n < 3000; n++) begin
            period_end = (n % 3 == 2);
            tick1();
            if (duty_valid) p++;
            if (n >= 8 && !busy && duty_out == 8'(exp_d) && target_out == 8'(s)) break;
        end
        period_end = 0;
        check({tag, "_duty"}, int'(duty_out), exp_d);
        check({tag, "_target"}, int'(target_out), s);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_pulses"}, p, exp_p);
    endtask

    task automatic run4(input bit re, input int s, input int exp_p, input string tag);
        int p;
        p = 0;
        ramp4 = re;
        sw4 = 8'(s);
        for (int n = 0; n < 3000; n++) begin
            pe4 = (n % 3 == 2);
            tick1();
            if (valid4) p++;
            if (n >= 8 && !busy4 && duty4 == 8'(s) && target4 == 8'(s)) break;
        end
        pe4 = 0;
        check({tag, "_duty"}, int'(duty4), s);
        check({tag, "_busy"}, int'(busy4), 0);
        check({tag, "_pulses"}, p, exp_p);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rec_t tbl[7];
        int   q[$];
        int   v;
        int   n;
        tbl[0] = '{1, 5, 5, 5};
        tbl[1] = '{0, 200, 200, 1};
        tbl[2] = '{1, 195, 195, 5};
        tbl[3] = '{1, 198, 198, 3};
        tbl[4] = '{0, 255, 255, 1};
        tbl[5] = '{1, 252, 252, 3};
        tbl[6] = '{1, 255, 255, 3};

        model_reset();
        #2 rst_n = 0;
        #1;
        check("rst_duty", int'(duty_out), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_valid", int'(duty_valid), 0);
        check_model();
        @(posedge clk);
        #1 rst_n = 1;

        for (int i = 0; i < 7; i++)
            run_rec(tbl[i].re, tbl[i].sw, tbl[i].exp_duty, tbl[i].pulses, $sformatf("rec%0d", i));

        run_rec(0, 100, 100, 1, "simul_jump");
        ramp_en = 1;
        sw = 8'd103;
        for (n = 0; n < 30; n++) begin
            tick1();
            if (busy) break;
        end
        check("simul_busy_wait", int'(busy), 1);
        for (n = 0; n < 20; n++) begin
            period_end = (m_edges % SDIV) == SDIV - 1;
            tick1();
            if (period_end) break;
        end
        period_end = 0;
        check("simul_no_commit_duty", int'(duty_out), 100);
        check("simul_no_commit_valid", int'(duty_valid), 0);
        tick1();
        period_end = 1;
        tick1();
        period_end = 0;
        check("simul_later_duty", int'(duty_out), 101);
        check("simul_later_valid", int'(duty_valid), 1);
        run_rec(1, 103, 103, 2, "simul_finish");

        run_rec(0, 40, 40, 1, "pre_rst");
        ramp_en = 1;
        sw = 8'd30;
        for (n = 0; n < 300; n++) begin
            period_end = (n % 3 == 2);
            tick1();
            if (duty_out == 8'd37) break;
        end
        period_end = 0;
        check("midramp_duty_wait", int'(duty_out), 37);
        rst_n = 0;
        model_reset();
        #1;
        check("midrst_duty", int'(duty_out), 0);
        check("midrst_busy", int'(busy), 0);
        check("midrst_valid", int'(duty_valid), 0);
        check("midrst_target", int'(target_out), 0);
        check("midrst_duty4", int'(duty4), 0);
        check_model();
        @(posedge clk);
        #1;
        sw = 8'h00;
        rst_n = 1;

        ramp_en = 1;
        for (int i = 0; i < 8; i++) begin
            sw = (i % 2 == 0) ? 8'h10 : 8'h00;
            repeat (2) begin
                tick1();
                check("chatter_target", int'(target_out), 0);
            end
        end
        sw = 8'h10;
        for (int c = 1; c <= 7; c++) begin
            tick1();
            check($sformatf("settle_target_c%0d", c), int'(target_out), (c == 7) ? 8'h10 : 0);
        end

        run4(0, 2, 1, "s4_jump2");
        run4(1, 0, 1, "s4_clamp0");
        ramp4 = 1;
        sw4 = 8'd20;
        for (n = 0; n < 300; n++) begin
            pe4 = (n % 3 == 2);
            tick1();
            if (duty4 == 8'd12) break;
        end
        pe4 = 0;
        check("s4_reach12", int'(duty4), 12);
        sw4 = 8'd6;
        for (n = 0; n < 20; n++) begin
            tick1();
            if (target4 == 8'd6) break;
        end
        check("s4_target6", int'(target4), 6);
        for (n = 0; n < 300; n++) begin
            pe4 = (n % 3 == 2);
            tick1();
            if (valid4) q.push_back(int'(duty4));
            if (!busy4) break;
        end
        pe4 = 0;
        check("s4_rev_count", q.size(), 2);
        if (q.size() == 2) begin
            check("s4_rev_step0", q[0], 8);
            check("s4_rev_step1", q[1], 6);
        end
        check("s4_rev_busy", int'(busy4), 0);
        run4(0, 250, 1, "s4_jump250");
        run4(1, 255, 2, "s4_clamp255");

        ramp_en = 1;
        for (n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 39) == 0) begin
                if ($urandom_range(0, 3) == 0) sw = 8'($urandom_range(0, 255));
                else begin
                    v = m_tgt + int'($urandom_range(0, 16)) - 8;
                    sw = 8'((v < 0) ? 0 : (v > 255) ? 255 : v);
                end
            end
            if ($urandom_range(0, 59) == 0) ramp_en = ~ramp_en;
            period_end = ($urandom_range(0, 2) == 0);
            tick1();
        end
        period_end = 0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
